// File: rtl/seq_memory_stage.sv
// rtl/seq_memory_stage.sv - Y86-64 SEQ memory stage: access decode, word-addressed data memory, address-error check
module seq_memory_stage #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  opcode,
    input  logic [7:0]  rArB,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic [63:0] addr,
    output logic [63:0] val_write,
    output logic        wrEn,
    output logic        reEn,
    output logic [63:0] valM,
    output logic        memerror
);

    localparam int          IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [63:0] LIMIT = 64'(MEM_WORDS);

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [63:0]      mem [MEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic [3:0]       icode;
    logic             unused_inputs;

    // rArB and ifun take no part in the memory access
    assign unused_inputs = ^{rArB, opcode[3:0]};
    assign icode         = opcode[7:4];

    always_comb begin
        addr      = '0;
        val_write = '0;
        wrEn      = 1'b0;
        reEn      = 1'b0;
        case (icode)
            I_RMMOVQ: begin addr = valE; val_write = valA; wrEn = 1'b1; end
            I_MRMOVQ: begin addr = valE; reEn = 1'b1; end
            I_CALL:   begin addr = valE; val_write = valP; wrEn = 1'b1; end
            I_RET:    begin addr = valA; reEn = 1'b1; end
            I_PUSHQ:  begin addr = valE; val_write = valA; wrEn = 1'b1; end
            I_POPQ:   begin addr = valA; reEn = 1'b1; end
            default:  ;
        endcase
    end

    // Full 64-bit compare so high address bits cannot alias into range
    assign memerror = (wrEn | reEn) & (addr >= LIMIT);
    assign idx      = addr[IDX_W-1:0];
    assign valM     = (reEn && !memerror) ? mem[idx] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wrEn && !memerror) begin
            mem[idx] <= val_write;
        end
    end

endmodule

// File: tb/tb_seq_memory_stage.sv
// tb/tb_seq_memory_stage.sv - self-checking bench for seq_memory_stage
module tb_seq_memory_stage;

    logic        clk;
    logic        reset;
    logic [7:0]  opcode;
    logic [7:0]  rArB;
    logic [63:0] valA;
    logic [63:0] valE;
    logic [63:0] valP;
    logic [63:0] addr;
    logic [63:0] val_write;
    logic        wrEn;
    logic        reEn;
    logic [63:0] valM;
    logic        memerror;

    int passed = 0;
    int total  = 0;
    bit checking = 1'b0;

    logic [63:0] model [0:1023];

    seq_memory_stage #(.MEM_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .rArB(rArB),
        .valA(valA), .valE(valE), .valP(valP), .addr(addr),
        .val_write(val_write), .wrEn(wrEn), .reEn(reEn),
        .valM(valM), .memerror(memerror)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference behaviour: which operand is the address/data for each instruction class
    task automatic predict(output logic [63:0] ea, output logic [63:0] wd,
                           output logic w, output logic r,
                           output logic err, output logic [63:0] rd);
        ea = 0; wd = 0; w = 0; r = 0;
        case (opcode[7:4])
            4'h4, 4'hA: begin ea = valE; wd = valA; w = 1; end
            4'h8:       begin ea = valE; wd = valP; w = 1; end
            4'h5:       begin ea = valE; r = 1; end
            4'h9, 4'hB: begin ea = valA; r = 1; end
            default: ;
        endcase
        err = (w || r) && (ea > 64'd1023);
        rd  = (r && !err) ? model[ea[9:0]] : 64'd0;
    endtask

    always @(negedge clk) begin
        logic [63:0] ea, wd, rd;
        logic w, r, err;
        if (checking) begin
            predict(ea, wd, w, r, err, rd);
            chk("addr", addr, ea);
            chk("val_write", val_write, wd);
            chk("wrEn", {63'd0, wrEn}, {63'd0, w});
            chk("reEn", {63'd0, reEn}, {63'd0, r});
            chk("memerror", {63'd0, memerror}, {63'd0, err});
            chk("valM", valM, rd);
        end
    end

    always @(posedge clk) begin
        logic [63:0] ea, wd, rd;
        logic w, r, err;
        predict(ea, wd, w, r, err, rd);
        if (reset && w && !err) model[ea[9:0]] = wd;
    end

    always @(negedge reset) begin
        for (int i = 0; i < 1024; i++) model[i] = 64'd0;
    end

    task automatic apply(input logic [7:0] op, input logic [7:0] rr,
                         input logic [63:0] a, input logic [63:0] e, input logic [63:0] p);
        opcode = op; rArB = rr; valA = a; valE = e; valP = p;
        @(negedge clk); #1;
    endtask

    task automatic next_cycle;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] probe [4];
        probe[0] = 64'd0; probe[1] = 64'd5; probe[2] = 64'd3; probe[3] = 64'd1023;
        for (int i = 0; i < 1024; i++) model[i] = 64'd0;
        reset = 1'b1; opcode = 8'h50; rArB = 8'h00; valA = 0; valE = 64'd5; valP = 0;
        #3 reset = 1'b0;
        #1 chk("reset_valM", valM, 64'd0);
        checking = 1'b1;
        next_cycle();
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            apply(8'h50, 8'h00, 0, probe[i], 0);
            chk("post_reset_zero", valM, 64'd0);
            next_cycle();
        end

        apply(8'hA0, 8'h8F, 64'd80, 64'd1000, 64'd80);
        chk("push_addr", addr, 64'd1000);
        chk("push_wdata", val_write, 64'd80);
        chk("push_wren", {63'd0, wrEn}, 64'd1);
        chk("push_reen", {63'd0, reEn}, 64'd0);
        chk("push_err", {63'd0, memerror}, 64'd0);
        next_cycle();

        apply(8'hB0, 8'h80, 64'd1000, 64'd1000, 64'd90);
        chk("pop_addr", addr, 64'd1000);
        chk("pop_reen", {63'd0, reEn}, 64'd1);
        chk("pop_valM", valM, 64'd80);
        next_cycle();

        apply(8'h80, 8'h00, 0, 64'd500, 64'd90);
        chk("call_wren", {63'd0, wrEn}, 64'd1);
        chk("call_wdata", val_write, 64'd90);
        next_cycle();
        apply(8'h90, 8'h00, 64'd500, 0, 0);
        chk("ret_reen", {63'd0, reEn}, 64'd1);
        chk("ret_valM", valM, 64'd90);
        next_cycle();

        apply(8'h40, 8'h00, 64'd7, 64'd1024, 0);
        chk("oor_write_err", {63'd0, memerror}, 64'd1);
        next_cycle();
        apply(8'h50, 8'h00, 0, 64'd1024, 0);
        chk("oor_read_err", {63'd0, memerror}, 64'd1);
        chk("oor_read_valM", valM, 64'd0);
        next_cycle();
        apply(8'h50, 8'h00, 0, 64'd0, 0);
        chk("no_alias_write", valM, 64'd0);
        next_cycle();
        apply(8'h40, 8'h00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("oor_max_err", {63'd0, memerror}, 64'd1);
        next_cycle();
        apply(8'h5F, 8'h00, 0, 64'd1023, 0);
        chk("top_word_ok", {63'd0, memerror}, 64'd0);
        next_cycle();

        apply(8'h10, 8'h12, 64'd55, 64'd66, 64'd77);
        chk("nop_addr", addr, 64'd0);
        chk("nop_valM", valM, 64'd0);
        next_cycle();
        apply(8'h60, 8'h12, 64'd55, 64'd66, 64'd77);
        chk("opq_wdata", val_write, 64'd0);
        chk("opq_wren", {63'd0, wrEn}, 64'd0);
        next_cycle();

        apply(8'h40, 8'h00, 64'd99, 64'd3, 0);
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        apply(8'h50, 8'h00, 0, 64'd3, 0);
        chk("midreset_mem3", valM, 64'd0);
        next_cycle();
        apply(8'hB0, 8'h00, 64'd1000, 0, 0);
        chk("midreset_cleared", valM, 64'd0);
        next_cycle();

        checking = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_memory_stage.md
# seq_memory_stage

Memory stage of the single-cycle (SEQ) Y86-64 processor. It decodes the instruction opcode into a data-memory address, write data and read/write enables. It contains the 64-bit-word data memory itself and returns the loaded value (valM) and an address-error flag. It sits between the execute stage (valE) and write-back/PC-update (valM, memerror).

## Interface
Parameters:
- MEM_WORDS, 1024, number of 64-bit words in data memory; legal addresses 0..MEM_WORDS-1

Ports:
- clk  input  1  system clock; writes commit on rising edge
- reset  input  1  asynchronous, active-low reset
- opcode  input  8  instruction byte; [7:4] icode, [3:0] ifun
- rArB  input  8  register specifier byte; unused by this block, accepted for interface uniformity
- valA  input  64  register operand A
- valE  input  64  ALU result / computed address
- valP  input  64  incremented PC (return address)
- addr  output  64  selected memory address (observability)
- val_write  output  64  selected write data (observability)
- wrEn  output  1  write enable (observability)
- reEn  output  1  read enable (observability)
- valM  output  64  value read from memory
- memerror  output  1  address out of range on an enabled access

## Operation
Combinational decode by icode:
- 4 rmmovq: addr=valE, val_write=valA, wrEn=1
- 5 mrmovq: addr=valE, reEn=1
- 8 call: addr=valE, val_write=valP, wrEn=1
- 9 ret: addr=valA, reEn=1
- A pushq: addr=valE, val_write=valA, wrEn=1
- B popq: addr=valA, reEn=1
- All other icodes: addr=0, val_write=0, wrEn=0, reEn=0. Unselected fields (val_write on reads) are 0.
- ifun is ignored.
- wrEn and reEn are never both 1.

Memory:
- Word-addressed array of MEM_WORDS × 64 bits; addr is used directly as word index, with no byte scaling.
- memerror = (wrEn | reEn) & (addr >= MEM_WORDS), using a full 64-bit unsigned compare.
- valM = mem[addr] when reEn & ~memerror, else 0.
- Write: at rising clk, if wrEn & ~memerror & reset, then mem[addr] <= val_write. An erroring write leaves memory unchanged.

## Timing
- Decode, memerror and valM are purely combinational from the inputs and current memory contents, with zero-cycle latency.
- A write takes effect at the rising edge that ends the cycle. A read in the following cycle returns the new value. A read in the same cycle, before the edge, returns the old value.
- Reset (reset=0) asynchronously clears every memory word to 0, with priority over writes. While held low, no write occurs.
- Outputs during reset:
  - valM=0, since memory is zero.
  - Decode outputs follow the inputs.
  - memerror follows the inputs.
- Reset asserted mid-operation discards any pending write in that cycle.
- Memory has no other initialisation. The contents after reset deassertion are all 0.

## Test plan
- Reset: pulse reset=0 with opcode=8'h50, valE=5 -> valM=0, and every location reads 0 afterwards.
- pushq: opcode=8'hA0, rArB=8'h8F, valA=80, valE=1000, valP=80 -> addr=1000, val_write=80, wrEn=1, reEn=0, memerror=0; after one edge mem[1000]=80.
- popq follow-up: opcode=8'hB0, rArB=8'h80, valA=1000, valE=1000, valP=90 -> addr=1000, reEn=1, wrEn=0, valM=80, memerror=0.
- call/ret: opcode=8'h80, valE=500, valP=90, then one edge, then opcode=8'h90, valA=500 -> first wrEn=1 with val_write=90; then reEn=1, valM=90.
- Out of range: opcode=8'h40, valE=1024, valA=7 -> memerror=1, no write (mrmovq from 1024 would also give memerror=1, valM=0). Repeat with valE=64'hFFFF_FFFF_FFFF_FFFF -> memerror=1.
- Non-memory op and mid-write reset:
  - opcode=8'h10 (nop) or 8'h60 (OPq) -> addr=0, val_write=0, wrEn=0, reEn=0, memerror=0, valM=0.
  - Assert reset=0 during an rmmovq to address 3 before the edge -> mem[3] remains 0.
